// File: rtl/uart_rx_qi8_if.sv
// Received-byte channel of the UART receiver: one-entry valid/ready
// handshake plus the frame-error and overrun status pulses.
interface uart_rx_qi8_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready,
    output frame_err,
    output overrun
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_qi8.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM and a
// one-entry output register with valid/ready handshake and overrun flag.
module uart_rx_qi8 #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_rx_qi8_if.master bus
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx_qi8: clocks per bit must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          commit_reg, commit_next;
  logic          ferr_reg, ferr_next;

  logic [1:0]    sync_reg;
  logic          rxs;

  logic [7:0]    data_reg;
  logic          valid_reg;
  logic          overrun_reg;

  // Synchroniser resets to the idle-line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rxs = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      commit_reg <= 1'b0;
      ferr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      commit_reg <= commit_next;
      ferr_reg   <= ferr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    commit_next = 1'b0;
    ferr_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (!rxs) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxs, shift_reg[7:1]};
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      // Leaving at the stop-bit midpoint lets an immediately following start edge be seen.
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rxs) begin
            commit_next = 1'b1;
            state_next  = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      BREAK: begin
        if (rxs) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A commit always wins over a consume, so a same-cycle handshake keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (commit_reg) begin
        data_reg    <= shift_reg;
        valid_reg   <= 1'b1;
        overrun_reg <= valid_reg && !bus.out_ready;
      end else if (valid_reg && bus.out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_reg;
  assign bus.out_valid = valid_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_err = ferr_reg;

endmodule

// File: tb/tb_uart_rx_qi8.sv
// Self-checking bench for uart_rx_qi8 at CPB=8: directed frame scenarios plus
// randomized bytes, line rates and consumer back-pressure against a byte queue.
module tb_uart_rx_qi8;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 125_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int BIT_T    = CPB * 10;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_qi8_if bus ();

  uart_rx_qi8 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err === 1'b1) ferr_cnt++;
      if (bus.overrun === 1'b1)   ovr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one 8N1 frame, LSB first; a low stop bit leaves the line low.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_t);
    end
    rx = stop;
    #(bit_t);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx = 1'b1;
    bus.out_ready = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({bus.out_data, bus.out_valid, bus.frame_err, bus.overrun} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b ovr=%b, want all 0",
               bus.out_data, bus.out_valid, bus.frame_err, bus.overrun);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_hold_and_consume;
    bit ok;
    send_frame(8'hA5, 1'b1, BIT_T);
    wait_valid(100, ok);
    n_checks++;
    if (!ok || bus.out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_receive: got valid=%b data=%h, want valid=1 data=a5", bus.out_valid, bus.out_data);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_hold: got valid=%b data=%h, want valid=1 data=a5", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_consume: got valid=%b, want 0", bus.out_valid);
    end
    $display("frame a5 received and consumed");
  endtask

  task automatic test_glitch;
    bit ok;
    int f0 = ferr_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || ferr_cnt != f0) begin
      n_fail++;
      $display("FAIL glitch_reject: got valid=%b ferr_pulses=%0d, want valid=0 ferr_pulses=0",
               bus.out_valid, ferr_cnt - f0);
    end
    send_frame(8'h5C, 1'b1, BIT_T);
    wait_valid(100, ok);
    n_checks++;
    if (!ok || bus.out_data !== 8'h5C) begin
      n_fail++;
      $display("FAIL glitch_followup: got valid=%b data=%h, want valid=1 data=5c", bus.out_valid, bus.out_data);
    end
    consume();
    $display("glitch rejected, frame 5c received");
  endtask

  task automatic test_break;
    bit ok;
    int f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, BIT_T);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ferr_cnt - f0 != 1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL break_ferr: got ferr_pulses=%0d valid=%b, want ferr_pulses=1 valid=0",
               ferr_cnt - f0, bus.out_valid);
    end
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1, BIT_T);
    wait_valid(100, ok);
    n_checks++;
    if (!ok || bus.out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL break_recover: got valid=%b data=%h, want valid=1 data=5a", bus.out_valid, bus.out_data);
    end
    consume();
    $display("break gave one frame error, frame 5a received");
  endtask

  task automatic test_back_to_back;
    int o0 = ovr_cnt;
    bus.out_ready = 1'b0;
    send_frame(8'h11, 1'b1, BIT_T);
    send_frame(8'h22, 1'b1, BIT_T);
    repeat (30) @(negedge clk);
    n_checks++;
    if (ovr_cnt - o0 != 1 || bus.out_data !== 8'h22 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_overrun: got ovr_pulses=%0d data=%h valid=%b, want 1 22 1",
               ovr_cnt - o0, bus.out_data, bus.out_valid);
    end
    consume();
    $display("back-to-back 11,22 with one overrun");
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int f0 = ferr_cnt;
    fork
      send_frame(8'hFF, 1'b1, BIT_T);
      begin
        repeat (44) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({bus.out_data, bus.out_valid, bus.frame_err, bus.overrun} !== 11'h0) begin
          n_fail++;
          $display("FAIL midframe_reset: got data=%h valid=%b ferr=%b ovr=%b, want all 0",
                   bus.out_data, bus.out_valid, bus.frame_err, bus.overrun);
        end
      end
    join
    repeat (20) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || ferr_cnt != f0) begin
      n_fail++;
      $display("FAIL midframe_discard: got valid=%b ferr_pulses=%0d, want 0 0", bus.out_valid, ferr_cnt - f0);
    end
    send_frame(8'h7E, 1'b1, BIT_T);
    wait_valid(100, ok);
    n_checks++;
    if (!ok || bus.out_data !== 8'h7E) begin
      n_fail++;
      $display("FAIL midframe_next: got valid=%b data=%h, want valid=1 data=7e", bus.out_valid, bus.out_data);
    end
    consume();
    $display("partial ff discarded by reset, frame 7e received");
  endtask

  task automatic test_commit_with_ready;
    int lat = 0;
    int o0 = ovr_cnt;
    bus.out_ready = 1'b0;
    @(negedge clk);
    fork
      send_frame(8'h44, 1'b1, BIT_T);
      while (bus.out_valid !== 1'b1 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
    join
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h44) begin
      n_fail++;
      $display("FAIL commit_first: got valid=%b data=%h, want valid=1 data=44", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    fork
      send_frame(8'h99, 1'b1, BIT_T);
      begin
        repeat (lat - 1) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h99) begin
          n_fail++;
          $display("FAIL commit_ready: got valid=%b data=%h, want valid=1 data=99", bus.out_valid, bus.out_data);
        end
      end
    join
    repeat (4) @(negedge clk);
    n_checks++;
    if (ovr_cnt != o0 || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_no_overrun: got ovr_pulses=%0d valid=%b, want 0 1", ovr_cnt - o0, bus.out_valid);
    end
    consume();
    $display("ready in commit cycle: 99 kept valid, latency %0d cycles", lat);
  endtask

  task automatic test_random;
    localparam int N = 20;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    fork
      for (int i = 0; i < N; i++) begin
        logic [7:0] b = 8'($urandom);
        int bit_t = BIT_T + $urandom_range(0, 2) - 1;
        exp_q.push_back(b);
        #($urandom_range(0, 20) * 10);
        send_frame(b, 1'b1, bit_t);
      end
      begin
        int got = 0;
        int held = 0;
        int budget = N * 250;
        while (got < N && budget > 0) begin
          @(negedge clk);
          budget--;
          held = (bus.out_valid === 1'b1) ? held + 1 : 0;
          bus.out_ready = ($urandom_range(0, 3) == 0) || held > 20;
          if (bus.out_valid === 1'b1 && bus.out_ready) begin
            logic [7:0] e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (bus.out_data !== e) begin
              n_fail++;
              $display("FAIL random_byte: got %h, want %h", bus.out_data, e);
            end else begin
              $display("rx byte %h matches model", bus.out_data);
            end
            got++;
            held = 0;
          end
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if (got != N) begin
          n_fail++;
          $display("FAIL random_timeout: got %0d bytes, want %0d", got, N);
        end
      end
    join
    repeat (20) @(negedge clk);
    n_checks++;
    if (ferr_cnt != f0 || ovr_cnt != o0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_status: got ferr=%0d ovr=%0d valid=%b, want 0 0 0",
               ferr_cnt - f0, ovr_cnt - o0, bus.out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_hold_and_consume();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_commit_with_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
